// File: rtl/lab_sweep_ctrl_if.sv
// Sweep controller bus: run control, DUT stimulus {a,s,d} and DUT response {x,y}, status.
// Latency: none, wires only.
// Backpressure: none; start is a request level sampled only while the controller is idle.
// master = sequencer/bench side (drives start, abort, dut_x, dut_y)
// slave  = lab_sweep_ctrl (drives a, s, d, busy, done, pass, err_cnt, vec_idx[, fail_mask])
// fail_mask exists only when SWEEP_FAIL_LOG_EN is defined.
interface lab_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       dut_x;
  logic       dut_y;
  logic       a;
  logic       s;
  logic       d;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] vec_idx;
`ifdef SWEEP_FAIL_LOG_EN
  logic [7:0] fail_mask;
`endif

  modport master (
    output start, abort, dut_x, dut_y,
    input  a, s, d, busy, done, pass, err_cnt, vec_idx
`ifdef SWEEP_FAIL_LOG_EN
    , input fail_mask
`endif
  );

  modport slave (
    input  start, abort, dut_x, dut_y,
    output a, s, d, busy, done, pass, err_cnt, vec_idx
`ifdef SWEEP_FAIL_LOG_EN
    , output fail_mask
`endif
  );
endinterface

// File: rtl/lab_sweep_ctrl.sv
// Sweeps all 8 {a,s,d} vectors into a DUT and compares {x,y} against EXP_TABLE.
// Latency: DWELL+3 cycles per vector; start-to-done is 8*(DWELL+3)+1 cycles.
// Backpressure: start is ignored unless idle; abort wins over start and ends a sweep next cycle.
// Ports: clk, rst_n (async, active-low), bus (lab_sweep_ctrl_if.slave).
// Optional feature: SWEEP_FAIL_LOG_EN adds the per-vector fail_mask output.
module lab_sweep_ctrl #(
  parameter int unsigned DWELL     = 4,
  parameter logic [15:0] EXP_TABLE = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  lab_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic [3:0] dwell_q, dwell_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic       pass_q, pass_d;
`ifdef SWEEP_FAIL_LOG_EN
  logic [7:0] fail_mask_q, fail_mask_d;
`endif

  // Expected {x,y} for the applied vector: bits [2i+1:2i] of the table.
  logic [15:0] exp_shift;
  logic        mismatch;

  always_comb begin
    exp_shift = EXP_TABLE >> {vec_idx_q, 1'b0};
    mismatch  = ({bus.dut_x, bus.dut_y} != exp_shift[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_idx_q   <= '0;
      dwell_q     <= '0;
      err_cnt_q   <= '0;
      pass_q      <= 1'b0;
`ifdef SWEEP_FAIL_LOG_EN
      fail_mask_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      dwell_q     <= dwell_d;
      err_cnt_q   <= err_cnt_d;
      pass_q      <= pass_d;
`ifdef SWEEP_FAIL_LOG_EN
      fail_mask_q <= fail_mask_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    dwell_d     = dwell_q;
    err_cnt_d   = err_cnt_q;
    pass_d      = pass_q;
`ifdef SWEEP_FAIL_LOG_EN
    fail_mask_d = fail_mask_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = APPLY;
          vec_idx_d   = '0;
          dwell_d     = '0;
          err_cnt_d   = '0;
`ifdef SWEEP_FAIL_LOG_EN
          fail_mask_d = '0;
`endif
        end
      end
      APPLY: begin
        dwell_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = SAMPLE;
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      SAMPLE: begin
        // At most one mismatch per vector, so the count tops out at 8.
        if (mismatch) begin
          err_cnt_d = err_cnt_q + 4'd1;
`ifdef SWEEP_FAIL_LOG_EN
          fail_mask_d[vec_idx_q] = 1'b1;
`endif
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (vec_idx_q != 3'd7) begin
          vec_idx_d = vec_idx_q + 3'd1;
          state_d   = APPLY;
        end else begin
          // Verdict is registered on entry to DONE so pass is valid alongside done.
          pass_d  = (err_cnt_q == 4'd0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the sweep: stimulus back to vector 0, results frozen for readout.
    if (bus.abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      vec_idx_d   = '0;
      dwell_d     = '0;
      err_cnt_d   = err_cnt_q;
      pass_d      = pass_q;
`ifdef SWEEP_FAIL_LOG_EN
      fail_mask_d = fail_mask_q;
`endif
    end
  end

  always_comb begin
    bus.a         = vec_idx_q[2];
    bus.s         = vec_idx_q[1];
    bus.d         = vec_idx_q[0];
    bus.vec_idx   = vec_idx_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.pass      = pass_q;
    bus.err_cnt   = err_cnt_q;
`ifdef SWEEP_FAIL_LOG_EN
    bus.fail_mask = fail_mask_q;
`endif
  end

endmodule

// File: tb/tb_lab_sweep_ctrl.sv
// Bench for lab_sweep_ctrl: a behavioural DUT answers {x,y} from its own copy of the table,
// with per-vector flip masks to inject mismatches; sweep scenarios are table-driven.
// Hand-written sequences cover start+abort in idle, start re-pulse, abort at vector 4, reset at vector 5.
module tb_lab_sweep_ctrl;

  localparam int unsigned DWELL     = 4;
  localparam logic [15:0] EXP_T     = 16'hB4E1;
  localparam int          PER       = DWELL + 3;
  localparam int          SWEEP_CYC = 8 * PER + 1;

  logic clk;
  logic rst_n;
  lab_sweep_ctrl_if bus ();

  lab_sweep_ctrl #(.DWELL(DWELL), .EXP_TABLE(EXP_T)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural lab DUT: correct answer from the table unless the flip mask says otherwise.
  logic [15:0] exp_tab;
  logic [7:0]  flip_x, flip_y;
  logic [2:0]  cur;
  assign exp_tab   = EXP_T;
  assign cur       = {bus.a, bus.s, bus.d};
  assign bus.dut_x = exp_tab[{cur, 1'b1}] ^ flip_x[cur];
  assign bus.dut_y = exp_tab[{cur, 1'b0}] ^ flip_y[cur];

  int n_chk;
  int n_err;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},    int'(bus.busy), 0);
    check({tag, "_done"},    int'(bus.done), 0);
    check({tag, "_pass"},    int'(bus.pass), 0);
    check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
    check({tag, "_vec_idx"}, int'(bus.vec_idx), 0);
    check({tag, "_asd"},     int'({bus.a, bus.s, bus.d}), 0);
`ifdef SWEEP_FAIL_LOG_EN
    check({tag, "_fail_mask"}, int'(bus.fail_mask), 0);
`endif
  endtask

  // Starts a sweep and watches 6 cycles past the expected end. Cycle c is the
  // c-th negedge after the edge that accepted start; bad counts sequence violations.
  task automatic run_sweep(input int repulse_at, output int done_cyc, output int done_cnt,
                           output int bad);
    int ev;
    done_cyc = 0;
    done_cnt = 0;
    bad      = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= SWEEP_CYC + 6; c++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      ev = (c < SWEEP_CYC) ? (c - 1) / PER : 7;
      if (int'(bus.vec_idx) != ev) bad++;
      if ({bus.a, bus.s, bus.d} != bus.vec_idx) bad++;
      if (bus.busy != (c <= SWEEP_CYC)) bad++;
      bus.start = (c == repulse_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_vec(input int v, output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (int'(bus.vec_idx) == v && bus.busy) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] fx;
    logic [7:0] fy;
    int         exp_err;
    int         exp_pass;
    logic [7:0] exp_mask;
  } scen_t;

  scen_t tbl [5];

  initial begin
    int done_cyc, done_cnt, bad, ok;

    tbl[0] = '{fx: 8'h00, fy: 8'h00, exp_err: 0, exp_pass: 1, exp_mask: 8'h00};
    tbl[1] = '{fx: 8'h48, fy: 8'h00, exp_err: 2, exp_pass: 0, exp_mask: 8'h48};
    tbl[2] = '{fx: 8'h00, fy: 8'hFF, exp_err: 8, exp_pass: 0, exp_mask: 8'hFF};
    tbl[3] = '{fx: 8'h01, fy: 8'h01, exp_err: 1, exp_pass: 0, exp_mask: 8'h01};
    tbl[4] = '{fx: 8'h80, fy: 8'h24, exp_err: 3, exp_pass: 0, exp_mask: 8'hA4};

    n_chk     = 0;
    n_err     = 0;
    flip_x    = 8'h00;
    flip_y    = 8'h00;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b1;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("rst_release");

    for (int i = 0; i < 5; i++) begin
      flip_x = tbl[i].fx;
      flip_y = tbl[i].fy;
      run_sweep(0, done_cyc, done_cnt, bad);
      check($sformatf("sc%0d_done_cycle", i), done_cyc, SWEEP_CYC);
      check($sformatf("sc%0d_done_pulses", i), done_cnt, 1);
      check($sformatf("sc%0d_sequence", i), bad, 0);
      check($sformatf("sc%0d_err_cnt", i), int'(bus.err_cnt), tbl[i].exp_err);
      check($sformatf("sc%0d_pass", i), int'(bus.pass), tbl[i].exp_pass);
      check($sformatf("sc%0d_vec_hold", i), int'(bus.vec_idx), 7);
`ifdef SWEEP_FAIL_LOG_EN
      check($sformatf("sc%0d_fail_mask", i), int'(bus.fail_mask), int'(tbl[i].exp_mask));
`endif
    end

    // start together with abort in IDLE: nothing starts, results untouched.
    flip_x = 8'h00;
    flip_y = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", int'(bus.busy), 0);
    check("start_abort_err_kept", int'(bus.err_cnt), 3);
    check("start_abort_vec_kept", int'(bus.vec_idx), 7);
    @(negedge clk);
    check("start_abort_busy_later", int'(bus.busy), 0);

    // start re-pulsed mid-sweep must not restart or extend it.
    run_sweep(20, done_cyc, done_cnt, bad);
    check("repulse_done_cycle", done_cyc, SWEEP_CYC);
    check("repulse_done_pulses", done_cnt, 1);
    check("repulse_sequence", bad, 0);
    check("repulse_pass", int'(bus.pass), 1);

    // Abort at vector 4 after one mismatch on vector 0; pass stays 1 from the previous sweep.
    flip_x = 8'h01;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_vec(4, ok);
    check("abort_reach_vec4", ok, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_vec_idx", int'(bus.vec_idx), 0);
    check("abort_asd", int'({bus.a, bus.s, bus.d}), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_pass_kept", int'(bus.pass), 1);
    check("abort_err_kept", int'(bus.err_cnt), 1);
`ifdef SWEEP_FAIL_LOG_EN
    check("abort_fail_mask", int'(bus.fail_mask), 1);
`endif
    done_cnt = 0;
    ok       = 0;
    for (int c = 0; c < SWEEP_CYC + 10; c++) begin
      if (bus.done) done_cnt++;
      if (bus.busy) ok++;
      @(negedge clk);
    end
    check("abort_no_done_after", done_cnt, 0);
    check("abort_stays_idle", ok, 0);

    // Reset while vector 5 is applied: outputs clear with no clock edge.
    flip_x = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_vec(5, ok);
    check("rst_reach_vec5", ok, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, done_cyc, done_cnt, bad);
    check("rst_resweep_done_cycle", done_cyc, SWEEP_CYC);
    check("rst_resweep_sequence", bad, 0);
    check("rst_resweep_pass", int'(bus.pass), 1);
    check("rst_resweep_err_cnt", int'(bus.err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lab_sweep_ctrl.md
LAB_SWEEP_CTRL -- requirements
Module: lab_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning settle cycles per vector (legal 1..15).
REQ-002 SHALL have parameter EXP_TABLE, default 16'h0000, 16 bits, meaning expected {x,y} for vector i at bits [2i+1:2i].
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one full sweep.
REQ-006 SHALL have port abort  input  1  terminate sweep in progress.
REQ-007 SHALL have port dut_x  input  1  DUT output x.
REQ-008 SHALL have port dut_y  input  1  DUT output y.
REQ-009 SHALL have port a  output  1  DUT input a, vector bit 2.
REQ-010 SHALL have port s  output  1  DUT input s, vector bit 1.
REQ-011 SHALL have port d  output  1  DUT input d, vector bit 0.
REQ-012 SHALL have port busy  output  1  sweep in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-014 SHALL have port pass  output  1  last completed sweep had zero mismatches.
REQ-015 SHALL have port err_cnt  output  4  mismatch count of current/last sweep.
REQ-016 SHALL have port vec_idx  output  3  vector currently applied.

Function
REQ-017 SHALL implement states IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE; {a,s,d} SHALL equal vec_idx at all times.
REQ-018 SHALL, in IDLE with start=1 and abort=0, clear err_cnt and vec_idx and enter APPLY next cycle; busy=1 from APPLY through DONE inclusive.
REQ-019 SHALL hold APPLY one cycle, then SETTLE exactly DWELL cycles (internal 4-bit dwell counter), then SAMPLE one cycle.
REQ-020 SHALL, in SAMPLE, compare {dut_x,dut_y} with EXP_TABLE[2*vec_idx+1 -: 2]; mismatch increments err_cnt by 1 (max 8, no overflow possible).
REQ-021 SHALL, in NEXT, increment vec_idx and return to APPLY if vec_idx<7, else enter DONE without wrapping vec_idx.
REQ-022 SHALL, in DONE, assert done for exactly one cycle, set pass=(err_cnt==0), return to IDLE; vec_idx holds 7 until next start.
REQ-023 SHALL give per-vector latency DWELL+3 cycles; full sweep start-to-done = 8*(DWELL+3)+1 cycles.
REQ-024 SHALL ignore start when not in IDLE.
REQ-025 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle, drive vec_idx=0, leave pass unchanged, and not assert done.
REQ-026 SHALL give abort priority over start when both are asserted in IDLE (remain IDLE).
REQ-027 SHALL leave err_cnt readable after DONE or abort until the next accepted start.

Reset
REQ-028 SHALL, on rst_n=0 asynchronously: state=IDLE, vec_idx=0, a=s=d=0, busy=0, done=0, pass=0, err_cnt=0, dwell counter=0.
REQ-029 SHALL, on reset mid-sweep, discard progress; first accepted start after release begins at vector 0.

Configuration
REQ-030 SHALL, with macro SWEEP_FAIL_LOG_EN defined, add output fail_mask (8 bits): bit i set in SAMPLE of vector i on mismatch, cleared on accepted start and reset, held after DONE/abort.
REQ-031 SHALL, without SWEEP_FAIL_LOG_EN, omit fail_mask port and its logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: DWELL=4, DUT matching EXP_TABLE, pulse start -> a,s,d step 000..111, done at cycle 57, pass=1, err_cnt=0.
REQ-033 SHALL cover: DUT x forced wrong on vectors 3 and 6 -> err_cnt=2, pass=0, fail_mask=8'h48 (macro on).
REQ-034 SHALL cover: abort while vec_idx=4 -> IDLE next cycle, busy=0, a=s=d=0, no done pulse, pass unchanged.
REQ-035 SHALL cover: start and abort asserted together in IDLE -> stays IDLE, busy=0.
REQ-036 SHALL cover: start re-pulsed mid-sweep -> ignored, sweep completes once with one done pulse.
REQ-037 SHALL cover: rst_n low at vector 5 -> all outputs reset immediately without clock edge; next start sweeps from 000.
